// File: rtl/requant_pkg.sv
// Shared widths, output limits and the per-beat sideband record for the
// INT32 -> INT8 requantization pipeline.
package requant_pkg;

    localparam int ACC_W   = 32;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 5;
    localparam int OUT_W   = 8;
    localparam int PROD_W  = ACC_W + SCALE_W;

    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef struct packed {
        logic signed [ACC_W-1:0]   acc;
        logic signed [SCALE_W-1:0] scale;
        logic        [SHIFT_W-1:0] shift;
        logic signed [OUT_W-1:0]   zp;
    } requant_beat_t;

endpackage

// File: rtl/requant_unit_rounding_shifter.sv
// Combinational round-half-up arithmetic right shift of the signed product.
// The result is one bit wider than the product so the rounding bias never overflows.
module rounding_shifter #(
    parameter int PROD_WIDTH  = 48,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [PROD_WIDTH-1:0]  prod,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [PROD_WIDTH:0]    rounded
);

    localparam int R_WIDTH = PROD_WIDTH + 1;

    logic signed [R_WIDTH-1:0] prod_ext;
    logic signed [R_WIDTH-1:0] bias;
    logic signed [R_WIDTH-1:0] biased;

    always_comb begin
        prod_ext = R_WIDTH'(prod);
        // Half an output LSB; only meaningful when shift is non-zero.
        bias     = R_WIDTH'(1) << (shift - SHIFT_WIDTH'(1));
        biased   = prod_ext + bias;
        if (shift == '0) begin
            rounded = prod_ext;
        end else begin
            rounded = biased >>> shift;
        end
    end

endmodule

// File: rtl/requant_unit.sv
// Three-stage valid/ready requantizer: multiply, rounding shift + zero point, saturate.
// Build option: define REQUANT_RELU_EN to clamp the low end at the zero point instead of -128.
module requant_unit
    import requant_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_W,
    parameter int SCALE_WIDTH = SCALE_W,
    parameter int SHIFT_WIDTH = SHIFT_W,
    parameter int OUT_WIDTH   = OUT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACC_WIDTH-1:0]   acc_in,
    input  logic signed [SCALE_WIDTH-1:0] scale_in,
    input  logic        [SHIFT_WIDTH-1:0] shift_in,
    input  logic signed [OUT_WIDTH-1:0]   zero_point_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   data_out,
    output logic                          sat_out
);

    localparam int PROD_WIDTH = ACC_WIDTH + SCALE_WIDTH;
    localparam int R_WIDTH    = PROD_WIDTH + 1;
    localparam int V_WIDTH    = PROD_WIDTH + 2;

    localparam logic signed [V_WIDTH-1:0] V_MAX = V_WIDTH'(OUT_MAX);
    localparam logic signed [V_WIDTH-1:0] V_MIN = V_WIDTH'(OUT_MIN);

    requant_beat_t in_beat;

    logic s1_valid, s2_valid, s3_valid;
    logic s1_ready, s2_ready, s3_ready;
    logic in_fire;

    logic signed [PROD_WIDTH-1:0]  s1_prod;
    logic        [SHIFT_WIDTH-1:0] s1_shift;
    logic signed [OUT_WIDTH-1:0]   s1_zp;
    logic signed [R_WIDTH-1:0]     s1_rounded;
    logic signed [V_WIDTH-1:0]     s1_v;

    logic signed [V_WIDTH-1:0]     s2_v;
`ifdef REQUANT_RELU_EN
    logic signed [OUT_WIDTH-1:0]   s2_zp;
`endif

    logic signed [V_WIDTH-1:0]     lo_bound;
    logic signed [OUT_WIDTH-1:0]   sat_data;
    logic                          sat_flag;

    logic signed [OUT_WIDTH-1:0]   s3_data;
    logic                          s3_sat;

    assign in_beat = '{acc: acc_in, scale: scale_in, shift: shift_in, zp: zero_point_in};

    // Each stage frees up when it is empty or its content moves on; bubbles collapse.
    assign s3_ready = !s3_valid || out_ready;
    assign s2_ready = !s2_valid || s3_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready && !flush;
    assign in_fire  = in_valid && in_ready;

    rounding_shifter #(
        .PROD_WIDTH  (PROD_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_rounding_shifter (
        .prod    (s1_prod),
        .shift   (s1_shift),
        .rounded (s1_rounded)
    );

    assign s1_v = V_WIDTH'(s1_rounded) + V_WIDTH'(s1_zp);

    always_comb begin
        lo_bound = V_MIN;
`ifdef REQUANT_RELU_EN
        lo_bound = V_WIDTH'(s2_zp);
`endif
        sat_data = s2_v[OUT_WIDTH-1:0];
        sat_flag = 1'b0;
        if (s2_v > V_MAX) begin
            sat_data = OUT_WIDTH'(OUT_MAX);
            sat_flag = 1'b1;
        end else if (s2_v < lo_bound) begin
            sat_data = lo_bound[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
            s2_v     <= '0;
`ifdef REQUANT_RELU_EN
            s2_zp    <= '0;
`endif
            s3_data  <= '0;
            s3_sat   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            if (s1_ready) s1_valid <= in_fire;
            if (s2_ready) s2_valid <= s1_valid;
            if (s3_ready) s3_valid <= s2_valid;

            if (in_fire) begin
                s1_prod  <= PROD_WIDTH'(in_beat.acc) * PROD_WIDTH'(in_beat.scale);
                s1_shift <= in_beat.shift;
                s1_zp    <= in_beat.zp;
            end
            if (s2_ready && s1_valid) begin
                s2_v  <= s1_v;
`ifdef REQUANT_RELU_EN
                s2_zp <= s1_zp;
`endif
            end
            // Output registers only change on a real load, so a stalled beat holds still.
            if (s3_ready && s2_valid) begin
                s3_data <= sat_data;
                s3_sat  <= sat_flag;
            end
        end
    end

    assign out_valid = s3_valid;
    assign data_out  = s3_data;
    assign sat_out   = s3_sat;

endmodule

// File: tb/tb_requant_unit.sv
// Self-checking bench for requant_unit: directed vector table, multi-cycle
// corner sequences and a randomized stream against an arithmetic reference.
module tb_requant_unit;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic signed [31:0] acc_in;
    logic signed [15:0] scale_in;
    logic        [4:0]  shift_in;
    logic signed [7:0]  zero_point_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0]  data_out;
    logic              sat_out;

    requant_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .acc_in        (acc_in),
        .scale_in      (scale_in),
        .shift_in      (shift_in),
        .zero_point_in (zero_point_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .sat_out       (sat_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int scale;
        int shift;
        int zp;
        int exp_d;
        bit exp_s;
        int relu_d;
        bit relu_s;
    } vec_t;

    typedef struct {
        int d;
        bit s;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;
    int cur_acc, cur_scale, cur_shift, cur_zp;
    int tx_cnt, rx_cnt;
    bit mon_en = 0;
    bit last_accepted = 0;
    bit prev_stall = 0;
    logic signed [7:0] prev_data;
    logic prev_sat;
    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact product, round half up via floor division, zero point, clamp.
    function automatic exp_t ref_model(input int acc, input int scale, input int shift, input int zp);
        exp_t   e;
        longint p, num, den, q, v, lo;
        p = longint'(acc) * longint'(scale);
        if (shift == 0) begin
            q = p;
        end else begin
            den = longint'(1) << shift;
            num = p + den / 2;
            q   = num / den;
            if ((num % den) != 0 && num < 0) q = q - 1;
        end
        v = q + longint'(zp);
`ifdef REQUANT_RELU_EN
        lo = longint'(zp);
`else
        lo = -128;
`endif
        if (v > 127) begin
            e.d = 127; e.s = 1'b1;
        end else if (v < lo) begin
            e.d = int'(lo); e.s = 1'b1;
        end else begin
            e.d = int'(v); e.s = 1'b0;
        end
        return e;
    endfunction

    task automatic drive(input int acc, input int scale, input int shift, input int zp);
        cur_acc   = acc;
        cur_scale = scale;
        cur_shift = shift;
        cur_zp    = zp;
        acc_in        = acc;
        scale_in      = scale[15:0];
        shift_in      = shift[4:0];
        zero_point_in = zp[7:0];
    endtask

    task automatic gen_random();
        int a, s, sh, z;
        if ($urandom_range(1) == 1) begin
            a  = int'($urandom());
            sh = int'($urandom_range(31, 14));
        end else begin
            a  = int'($urandom_range(2000)) - 1000;
            sh = int'($urandom_range(31));
        end
        s = int'($urandom_range(65535)) - 32768;
        z = int'($urandom_range(255)) - 128;
        drive(a, s, sh, z);
    endtask

    function automatic vec_t mk(input int a, input int s, input int sh, input int z,
                                input int d, input bit st, input int rd, input bit rs);
        vec_t v;
        v.acc = a; v.scale = s; v.shift = sh; v.zp = z;
        v.exp_d = d; v.exp_s = st; v.relu_d = rd; v.relu_s = rs;
        return v;
    endfunction

    // Scoreboard monitor; samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        last_accepted = in_valid && in_ready;
        if (mon_en) begin
            chk("in_ready_vs_occupancy", in_ready, (sb.size() < 3 || out_ready) ? 1 : 0);
            if (prev_stall) begin
                chk("stall_hold_data", data_out, prev_data);
                chk("stall_hold_sat", sat_out, prev_sat);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
            prev_sat   = sat_out;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("stream_data", data_out, e.d);
                    chk("stream_sat", sat_out, e.s);
                    rx_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_model(cur_acc, cur_scale, cur_shift, cur_zp));
                tx_cnt++;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        @(posedge clk); #1;
        drive(v.acc, v.scale, v.shift, v.zp);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("vec_latency", lat, 3);
`ifdef REQUANT_RELU_EN
        chk("vec_data", data_out, v.relu_d);
        chk("vec_sat", sat_out, v.relu_s);
`else
        chk("vec_data", data_out, v.exp_d);
        chk("vec_sat", sat_out, v.exp_s);
`endif
    endtask

    initial begin
        int sent, outs;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0);

        // acc, scale, shift, zp, plain {data, sat}, ReLU {data, sat}
        vecs.push_back(mk(100, 16384, 15, 0, 50, 0, 50, 0));
        vecs.push_back(mk(3, 1, 1, 0, 2, 0, 2, 0));
        vecs.push_back(mk(-3, 1, 1, 0, -1, 0, 0, 1));
        vecs.push_back(mk(5, 1, 0, 0, 5, 0, 5, 0));
        vecs.push_back(mk(1000, 16384, 15, 0, 127, 1, 127, 1));
        vecs.push_back(mk(-100000, 1, 0, 0, -128, 1, 0, 1));
        vecs.push_back(mk(-5, 1, 0, 10, 5, 0, 10, 1));
        vecs.push_back(mk(-20, 1, 0, 10, -10, 0, 10, 1));
        vecs.push_back(mk(1073741824, 5, 31, 0, 3, 0, 3, 0));
        vecs.push_back(mk(-1073741824, 5, 31, 0, -2, 0, 0, 1));
        vecs.push_back(mk(-5, 1, 1, 0, -2, 0, 0, 1));
        vecs.push_back(mk(0, 7, 3, -128, -128, 0, -128, 0));
        vecs.push_back(mk(127, 1, 0, 0, 127, 0, 127, 0));
        vecs.push_back(mk(128, 1, 0, 0, 127, 1, 127, 1));
        vecs.push_back(mk(100, 1, 2, -3, 22, 0, 22, 0));
        vecs.push_back(mk(-7, 3, 2, 5, 0, 0, 5, 1));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_sat_out", sat_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: acc=1..8, consumer stalled in cycles 4..9
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        sb.delete(); tx_cnt = 0; rx_cnt = 0; prev_stall = 0; mon_en = 1;
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 4 && c <= 9);
            if (!in_valid || last_accepted) begin
                if (sent < 8) begin
                    drive(sent + 1, 1, 0, 0);
                    in_valid = 1'b1;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (c == 8) begin
                @(negedge clk);
                chk("bp_full_in_ready", in_ready, 0);
            end
        end
        chk("bp_outputs_received", rx_cnt, 8);
        chk("bp_scoreboard_empty", sb.size(), 0);

        // Randomized stream with random consumer stalls
        tx_cnt = 0; rx_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid || last_accepted) begin
                if ($urandom_range(9) < 7) begin
                    gen_random();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        if (!last_accepted && in_valid) begin
            // leave the pending beat offered until it is taken
            out_ready = 1'b1;
            for (int k = 0; k < 10 && !last_accepted; k++) begin
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_tx_rx_count", rx_cnt, tx_cnt);
        chk("rand_scoreboard_empty", sb.size(), 0);
        mon_en = 0;

        // Flush with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(10 + i, 1, 0, 0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        drive(99, 1, 0, 0);
        @(negedge clk);
        chk("flush_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready_next", in_ready, 1);
        outs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) outs++;
        end
        chk("flush_no_outputs", outs, 0);

        // Reset in the middle of a stalled stream
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(60, 1, 0, 0);
        in_valid = 1'b1;
        outs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                outs = 1;
                break;
            end
        end
        chk("pre_reset_out_valid", outs, 1);
        chk("pre_reset_data", data_out, 60);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_sat_out", sat_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        outs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) outs++;
        end
        chk("midrst_no_outputs", outs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
